data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words of storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-014 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  request rejected (see REQ-022).

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE with rst low.
REQ-017 SHALL accept a request at a rising edge where req_valid && req_ready; latch we, addr, size, unsigned, wdata at that edge.
REQ-018 On acceptance: LATENCY = 0 -> RESP; else -> WAIT with counter loaded to LATENCY-1.
REQ-019 In WAIT: decrement counter each edge; at counter = 0 -> RESP; resp_valid first high in cycle after edge k+LATENCY (k = acceptance edge).
REQ-020 Store commit and load read SHALL occur at the edge entering RESP; resp_rdata/resp_err registered at same edge and held stable while resp_valid high.
REQ-021 In RESP: resp_valid = 1; on edge with resp_ready high -> IDLE, resp_valid low next cycle; resp_ready high before resp_valid SHALL complete handshake on first RESP cycle; resp_ready low holds RESP indefinitely.
REQ-022 Error when: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; addr >= 4*DEPTH_WORDS. Error -> resp_err = 1, resp_rdata = 0, no memory write.
REQ-023 Store byte lanes: byte writes lane addr[1:0]; half writes lanes {addr[1],0}..+1; word writes all four; other lanes unchanged.
REQ-024 Load: select byte at addr[1:0] or half at addr[1]; extend to 32 bits per req_unsigned; word passes unchanged.
REQ-025 Word index = addr[log2(DEPTH_WORDS)+1:2]; no wrap-around aliasing (out-of-range is error per REQ-022).
REQ-026 Non-pipelined: at most one outstanding request; minimum spacing LATENCY+2 cycles between acceptances.
REQ-027 Inputs other than req_valid SHALL be ignored outside the acceptance edge.

Reset
REQ-028 rst high SHALL immediately force state IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0.
REQ-029 rst asserted in WAIT SHALL drop the pending request; an uncommitted store SHALL NOT modify memory.
REQ-030 Memory contents SHALL NOT be cleared by reset; req_ready = 1 first cycle after rst deasserts.

Verification
REQ-031 LATENCY=2: store word 0xDEADBEEF @0x10 accepted at edge k -> resp_valid high after edge k+2, resp_err=0, resp_rdata=0; load word @0x10 -> resp_rdata=0xDEADBEEF.
REQ-032 Store byte 0x80 @0x21, then loads @0x21: signed byte -> 0xFFFFFF80, unsigned byte -> 0x00000080; load word @0x20 shows only bits [15:8] changed.
REQ-033 Load half @0x13, word @0x22, size 11, word @0x400 (DEPTH_WORDS=256) -> each resp_err=1, resp_rdata=0, memory unchanged.
REQ-034 resp_ready held low 5 cycles in RESP -> resp_valid, resp_rdata stable 5 cycles, req_ready=0; release -> IDLE, req_ready=1 next cycle.
REQ-035 Store word 0x12345678 @0x30 accepted, rst pulsed during WAIT -> outputs zero immediately, no response; subsequent load @0x30 returns prior contents.
REQ-036 LATENCY=0 with resp_ready tied high: back-to-back requests accepted every 2 cycles, resp_valid one cycle per request.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data memory slave with a fixed response latency.
// Accepts one load/store at a time, with byte/half/word access and alignment/range error checking.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_commit;
  logic        w_we;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = (r_state == S_RESP);
  assign w_accept   = req_valid && req_ready;
  assign w_commit   = (w_accept && (LATENCY == 0)) || ((r_state == S_WAIT) && (r_cnt == '0));

  // With zero latency the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_we    = req_we;
      w_uns   = req_unsigned;
      w_addr  = req_addr;
      w_size  = req_size;
      w_wdata = req_wdata;
    end else begin
      w_we    = r_we;
      w_uns   = r_uns;
      w_addr  = r_addr;
      w_size  = r_size;
      w_wdata = r_wdata;
    end
  end

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_err = (w_addr >> (AW + 2)) != '0;
    case (w_size)
      2'b00:   ;
      2'b01:   if (w_addr[0]) w_err = 1'b1;
      2'b10:   if (w_addr[1:0] != 2'b00) w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    case (w_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_size)
      2'b00:   w_load = {{24{w_byte[7] & ~w_uns}}, w_byte};
      2'b01:   w_load = {{16{w_half[15] & ~w_uns}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    case (w_size)
      2'b00: begin
        w_be     = 4'b0001 << w_addr[1:0];
        w_wlanes = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
      end
    endcase
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (w_commit && w_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_wdata    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        resp_err   <= w_err;
        resp_rdata <= (w_we || w_err) ? '0 : w_load;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            if (LATENCY == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder: a LATENCY=2 instance with a byte-array
// reference model, plus a LATENCY=0 instance exercising back-to-back throughput.
module tb_data_mem_responder;
  localparam int unsigned LAT       = 2;
  localparam int unsigned MEM_BYTES = 1024;

  logic        clock = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_we0, req_unsigned0;
  logic [31:0] req_addr0, req_wdata0;
  logic [1:0]  req_size0;
  logic        resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  exp_t        q0[$];
  logic [7:0]  mb [MEM_BYTES];
  logic [31:0] mem0 [8];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          rr_rand = 1'b1;
  bit          prev_valid = 1'b0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clock(clock), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_size(req_size0), .req_unsigned(req_unsigned0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(1'b1), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, little-endian, any access of 1<<size bytes.
  function automatic void model(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int unsigned nb;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
    nb = 1 << sz;
    if (sz == 2'b11 || (a % nb) != 0 || a >= MEM_BYTES) begin
      er = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < int'(nb); i++) mb[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(mb[int'(a) + i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input bit track);
    int unsigned n = 0;
    exp_t e;
    @(posedge clock); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    while (!req_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout got req_ready=%b exp 1", req_ready);
    end else if (track) begin
      model(we, a, sz, uns, wd, e.rd, e.er);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_addr = $urandom; req_size = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1)); req_wdata = $urandom;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", q.size());
    end
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Checks every cycle resp_valid is high, so held responses must stay equal to the expectation.
  always @(negedge clock) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp got rdata=%h err=%b exp no response", resp_rdata, resp_err);
        end else begin
          chk("rdata", resp_rdata, q[0].rd);
          chk("err", 32'(resp_err), 32'(q[0].er));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (!prev_valid) chk("latency", cyc - q[0].acc, LAT);
          if (resp_ready) void'(q.pop_front());
        end
      end
      prev_valid = resp_valid;
    end
  end

  always @(negedge clock) begin
    if (!rst && resp_valid0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp0 got rdata=%h exp no response", resp_rdata0);
      end else begin
        chk("rdata0", resp_rdata0, q0[0].rd);
        chk("err0", 32'(resp_err0), 32'(q0[0].er));
        void'(q0.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int unsigned n;
    bit          prev_acc;
    int unsigned sent;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_size0 = '0; req_unsigned0 = 1'b0; req_wdata0 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_req_ready0", 32'(req_ready0), 32'd1);

    for (int w = 0; w < 256; w++) issue(1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 1'b1);

    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'h21, 2'b00, 1'b0, 32'h80, 1'b1);
    issue(1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'h400, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b1);
    issue(1'b1, 32'h13, 2'b01, 1'b0, 32'hFFFF, 1'b1);
    issue(1'b1, 32'h22, 2'b10, 1'b0, 32'h5A5A5A5A, 1'b1);
    issue(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1);
    drain();

    @(posedge clock); #1;
    rr_rand = 1'b0;
    resp_ready = 1'b0;
    issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("hold_wait_valid", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("release_valid", 32'(resp_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    rr_rand = 1'b1;
    drain();

    issue(1'b1, 32'h30, 2'b10, 1'b0, 32'h12345678, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("wait_rst_valid", 32'(resp_valid), 32'd0);
    chk("wait_rst_req_ready", 32'(req_ready), 32'd0);
    chk("wait_rst_rdata", resp_rdata, 32'd0);
    chk("wait_rst_err", 32'(resp_err), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    chk("wait_rst_req_ready_after", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 1'b1);

    for (int t = 0; t < 400; t++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
      else if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b1);
    end
    drain();

    // Zero-latency instance: requests held valid, expect accept/respond alternating every cycle.
    prev_acc = 1'b0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      chk("b2b_pattern", 32'(resp_valid0), 32'(prev_acc));
      if (req_ready0 && sent < 16) begin
        exp_t e;
        req_valid0 = 1'b1;
        req_we0 = (sent < 8);
        req_addr0 = 32'((sent % 8) * 4);
        req_size0 = 2'b10;
        req_unsigned0 = 1'b0;
        req_wdata0 = $urandom;
        e.er = 1'b0;
        e.acc = 0;
        if (req_we0) begin
          mem0[sent % 8] = req_wdata0;
          e.rd = '0;
        end else begin
          e.rd = mem0[sent % 8];
        end
        q0.push_back(e);
        sent++;
        prev_acc = 1'b1;
      end else begin
        if (req_ready0) req_valid0 = 1'b0;
        prev_acc = 1'b0;
      end
    end
    chk("b2b_sent", sent, 32'd16);
    chk("b2b_pending", q0.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
